// File: rtl/spi_master_if.sv
// SPI master bundle: start/ready word handshake, receive word, and the four SPI pins.
// Latency: none, signals only.
// Backpressure: ready gates start; there is no backpressure on rx_valid.
interface spi_master_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;

    // Controller side: owns the pins and the receive word.
    modport master (
        input  start,
        input  tx_data,
        input  miso,
        output ready,
        output rx_data,
        output rx_valid,
        output sclk,
        output cs_n,
        output mosi
    );

    // User/peripheral side: issues words and drives miso.
    modport slave (
        output start,
        output tx_data,
        output miso,
        input  ready,
        input  rx_data,
        input  rx_valid,
        input  sclk,
        input  cs_n,
        input  mosi
    );
endinterface

// File: rtl/spi_master.sv
// Single-frame SPI mode-0 master (MSB first), sclk derived from clk by an integer divider.
// Latency: accept to rx_valid is CLK_DIV*(1+2*DATA_WIDTH) clk cycles; ready returns GAP_CYCLES later.
// Backpressure: ready is low for the whole frame plus gap; a start seen while busy is dropped, never queued.
module spi_master #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int BW      = $clog2(DATA_WIDTH) + 1;

    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  miso_meta;
    logic                  miso_sync;

    // Control strobes decoded from state and the divider terminal count.
    logic tick;
    logic load;
    logic rise;
    logic fall;
    logic done;
    logic park;

    assign tick = (cnt == '0);

    // Two-flop synchronizer for the asynchronous miso pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= bus.miso;
            miso_sync <= miso_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; every phase ends on the divider terminal count.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        done      = 1'b0;
        park      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    rise      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (bus.sclk) begin
                        fall = 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = HOLD;
                        end
                    end else begin
                        rise = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    done      = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                // The gap's last edge is the edge that enters IDLE; a start already
                // present there is taken on that same edge so held-start frames run
                // at the minimum CLK_DIV*(1+2*DATA_WIDTH)+GAP_CYCLES period.
                if (tick) begin
                    if (bus.start) begin
                        load      = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        park      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Divider: reloads on accept and at every phase boundary, counts down otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= DIV_LOAD;
        end else if (state != IDLE) begin
            if (tick) begin
                cnt <= done ? GAP_LOAD : DIV_LOAD;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Datapath and pins: shift registers, bit counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            bus.ready    <= 1'b1;
            bus.cs_n     <= 1'b1;
            bus.sclk     <= 1'b0;
            bus.mosi     <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
        end else begin
            bus.rx_valid <= done;
            if (load) begin
                tx_sr     <= bus.tx_data;
                rx_sr     <= '0;
                bit_cnt   <= '0;
                bus.cs_n  <= 1'b0;
                bus.mosi  <= bus.tx_data[DATA_WIDTH-1];
                bus.ready <= 1'b0;
            end
            if (park) begin
                bus.ready <= 1'b1;
            end
            if (rise) begin
                bus.sclk <= 1'b1;
                rx_sr    <= {rx_sr[DATA_WIDTH-2:0], miso_sync};
                bit_cnt  <= bit_cnt + BW'(1);
            end
            if (fall) begin
                bus.sclk <= 1'b0;
                tx_sr    <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                // After the last bit the line is parked low for the hold phase.
                bus.mosi <= (bit_cnt == BIT_LAST) ? 1'b0 : tx_sr[DATA_WIDTH-2];
            end
            if (done) begin
                bus.cs_n    <= 1'b1;
                bus.rx_data <= rx_sr;
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: waveform model from the frame timing rules, loopback and a mode-0 slave model.
// Latency: pins checked every clk cycle against the arithmetic timing model.
// Backpressure: start pokes while busy and held start are exercised.
module tb_spi_master;
    localparam int DW    = 16;
    localparam int DIV   = 8;
    localparam int GAP   = 8;
    localparam int T_END = DIV * (1 + 2 * DW);
    localparam int T_RDY = T_END + GAP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    bit            loopback      = 1'b1;
    logic          slv_miso      = 1'b0;
    logic [DW-1:0] slv_word      = '0;
    logic [DW-1:0] slv_tx        = '0;
    logic [DW-1:0] slv_rx        = '0;
    logic          slv_prev_cs   = 1'b1;
    logic          slv_prev_sclk = 1'b0;

    logic [DW-1:0] got_rx[$];
    int            got_t[$];

    spi_master_if #(.DATA_WIDTH(DW)) bus ();

    spi_master #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (DIV),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.miso = loopback ? bus.mosi : slv_miso;

    // Behavioural mode-0 slave: loads on cs_n fall, captures on sclk rise, shifts on sclk fall.
    always @(bus.cs_n or bus.sclk) begin
        if (bus.cs_n !== 1'b0) begin
            slv_miso = slv_miso;
        end else if (slv_prev_cs === 1'b1) begin
            slv_tx   = slv_word;
            slv_rx   = '0;
            slv_miso = slv_word[DW-1];
        end else if (bus.sclk === 1'b1 && slv_prev_sclk === 1'b0) begin
            slv_rx = {slv_rx[DW-2:0], bus.mosi};
        end else if (bus.sclk === 1'b0 && slv_prev_sclk === 1'b1) begin
            slv_tx   = {slv_tx[DW-2:0], 1'b0};
            slv_miso = slv_tx[DW-1];
        end
        slv_prev_cs   = bus.cs_n;
        slv_prev_sclk = bus.sclk;
    end

    // Expected {cs_n, sclk, mosi} after edge t of a frame accepted at t=0 carrying word w.
    function automatic logic [2:0] pins_model(input int t, input logic [DW-1:0] w);
        logic s;
        logic m;
        int   k;
        if (t < 0 || t >= T_END) return 3'b100;
        s = (t >= DIV) && (((t - DIV) % (2 * DIV)) < DIV);
        k = t / (2 * DIV);
        m = (k < DW) ? w[DW-1-k] : 1'b0;
        return {1'b0, s, m};
    endfunction

    // Launch a frame from idle and compare every cycle against the model.
    task automatic watch(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input bit hold,
                         input int poke_t, input logic [DW-1:0] poke_dat, input int ncyc,
                         output int pin_err, output int first_bad, output int vld_err,
                         output int rdy_err, output int rises);
        logic [2:0]    exp_pins;
        logic [2:0]    got_pins;
        logic          prev_sclk;
        logic          exp_vld;
        logic          exp_rdy;
        logic [DW-1:0] w;
        int            tt;
        pin_err   = 0;
        first_bad = -1;
        vld_err   = 0;
        rdy_err   = 0;
        rises     = 0;
        prev_sclk = 1'b0;
        got_rx.delete();
        got_t.delete();
        bus.start   = 1'b1;
        bus.tx_data = w0;
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (hold && t >= T_RDY) begin
                tt = t - T_RDY;
                w  = w1;
            end else begin
                tt = t;
                w  = w0;
            end
            exp_pins = pins_model(tt, w);
            got_pins = {bus.cs_n, bus.sclk, bus.mosi};
            if (got_pins !== exp_pins) begin
                pin_err++;
                if (first_bad < 0) first_bad = t;
            end
            if (bus.sclk === 1'b1 && prev_sclk === 1'b0) rises++;
            prev_sclk = bus.sclk;
            exp_vld = (t == T_END) || (hold && t == T_RDY + T_END);
            if (bus.rx_valid !== exp_vld) vld_err++;
            if (bus.rx_valid === 1'b1) begin
                got_rx.push_back(bus.rx_data);
                got_t.push_back(t);
            end
            exp_rdy = hold ? (t >= 2 * T_RDY) : (t >= T_RDY);
            if (bus.ready !== exp_rdy) rdy_err++;
            if (hold && t + 1 <= T_RDY) begin
                bus.start   = 1'b1;
                bus.tx_data = (t + 1 == T_RDY) ? w1 : DW'($urandom);
            end else if (t + 1 == poke_t) begin
                bus.start   = 1'b1;
                bus.tx_data = poke_dat;
            end else begin
                bus.start   = 1'b0;
                bus.tx_data = DW'($urandom);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.start   = 1'($urandom);
            bus.tx_data = DW'($urandom);
            @(negedge clk);
            total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset ready got=%b want=1", bus.ready); end
            total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL reset cs_n got=%b want=1", bus.cs_n); end
            total++; if (bus.sclk !== 1'b0) begin bad++; $display("FAIL reset sclk got=%b want=0", bus.sclk); end
            total++; if (bus.mosi !== 1'b0) begin bad++; $display("FAIL reset mosi got=%b want=0", bus.mosi); end
            total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset rx_valid got=%b want=0", bus.rx_valid); end
            total++; if (bus.rx_data !== '0) begin bad++; $display("FAIL reset rx_data got=%h want=0", bus.rx_data); end
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        int pe, fb, ve, re, ri;
        loopback = 1'b1;
        watch(16'hA5C3, '0, 1'b0, -1, '0, T_RDY + 10, pe, fb, ve, re, ri);
        total++; if (pe !== 0) begin bad++; $display("FAIL loopback pins bad_cycles=%0d first_t=%0d want 0", pe, fb); end
        total++; if (ve !== 0) begin bad++; $display("FAIL loopback rx_valid timing bad_cycles=%0d want 0", ve); end
        total++; if (re !== 0) begin bad++; $display("FAIL loopback ready timing bad_cycles=%0d want 0", re); end
        total++; if (ri !== DW) begin bad++; $display("FAIL loopback sclk rises got=%0d want=%0d", ri, DW); end
        total++;
        if (got_rx.size() !== 1 || got_rx[0] !== 16'hA5C3) begin
            bad++; $display("FAIL loopback rx_data got=%h (n=%0d) want=a5c3", bus.rx_data, got_rx.size());
        end
        total++; if (bus.rx_data !== 16'hA5C3) begin bad++; $display("FAIL loopback rx_data hold got=%h want=a5c3", bus.rx_data); end
    endtask

    task automatic test_slave(input string name, input logic [DW-1:0] tx, input logic [DW-1:0] sw);
        int pe, fb, ve, re, ri;
        loopback = 1'b0;
        slv_word = sw;
        watch(tx, '0, 1'b0, -1, '0, T_RDY + 4, pe, fb, ve, re, ri);
        total++; if (pe !== 0) begin bad++; $display("FAIL %s pins bad_cycles=%0d first_t=%0d want 0", name, pe, fb); end
        total++; if (ve !== 0 || re !== 0) begin bad++; $display("FAIL %s handshake bad_valid=%0d bad_ready=%0d want 0", name, ve, re); end
        total++;
        if (got_rx.size() !== 1 || got_rx[0] !== sw) begin
            bad++; $display("FAIL %s master rx got=%h (n=%0d) want=%h", name, bus.rx_data, got_rx.size(), sw);
        end
        total++; if (slv_rx !== tx) begin bad++; $display("FAIL %s slave rx got=%h want=%h", name, slv_rx, tx); end
    endtask

    task automatic test_busy_drop();
        int pe, fb, ve, re, ri;
        loopback = 1'b1;
        watch(16'h1234, '0, 1'b0, 100, 16'hBEEF, 420, pe, fb, ve, re, ri);
        total++; if (pe !== 0) begin bad++; $display("FAIL busy_drop pins bad_cycles=%0d first_t=%0d want 0", pe, fb); end
        total++; if (ve !== 0 || re !== 0) begin bad++; $display("FAIL busy_drop handshake bad_valid=%0d bad_ready=%0d want 0", ve, re); end
        total++;
        if (got_rx.size() !== 1 || got_rx[0] !== 16'h1234) begin
            bad++; $display("FAIL busy_drop frames n=%0d rx=%h want n=1 rx=1234", got_rx.size(), bus.rx_data);
        end
    endtask

    task automatic test_back_to_back();
        int pe, fb, ve, re, ri;
        loopback = 1'b1;
        watch(16'h0001, 16'h8000, 1'b1, -1, '0, 2 * T_RDY + 10, pe, fb, ve, re, ri);
        total++; if (pe !== 0) begin bad++; $display("FAIL b2b pins bad_cycles=%0d first_t=%0d want 0", pe, fb); end
        total++; if (ve !== 0 || re !== 0) begin bad++; $display("FAIL b2b handshake bad_valid=%0d bad_ready=%0d want 0", ve, re); end
        total++; if (ri !== 2 * DW) begin bad++; $display("FAIL b2b sclk rises got=%0d want=%0d", ri, 2 * DW); end
        total++;
        if (got_rx.size() !== 2) begin
            bad++; $display("FAIL b2b frame count got=%0d want=2", got_rx.size());
        end else begin
            total++; if (got_rx[0] !== 16'h0001) begin bad++; $display("FAIL b2b rx0 got=%h want=0001", got_rx[0]); end
            total++; if (got_rx[1] !== 16'h8000) begin bad++; $display("FAIL b2b rx1 got=%h want=8000", got_rx[1]); end
            total++;
            if (got_t[1] - got_t[0] !== T_RDY) begin
                bad++; $display("FAIL b2b rx_valid spacing got=%0d want=%0d", got_t[1] - got_t[0], T_RDY);
            end
        end
    endtask

    task automatic test_reset_mid(input int t_rst);
        int            ve;
        logic [DW-1:0] tx;
        logic [DW-1:0] sw;
        ve       = 0;
        loopback = 1'b0;
        slv_word = DW'($urandom);
        bus.start   = 1'b1;
        bus.tx_data = DW'($urandom);
        for (int t = 0; t < t_rst; t++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.rx_valid !== 1'b0) ve++;
        end
        @(posedge clk);
        total++; if (bus.cs_n !== 1'b0) begin bad++; $display("FAIL reset_mid t=%0d cs_n before got=%b want=0", t_rst, bus.cs_n); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL reset_mid t=%0d cs_n got=%b want=1", t_rst, bus.cs_n); end
        total++; if (bus.sclk !== 1'b0) begin bad++; $display("FAIL reset_mid t=%0d sclk got=%b want=0", t_rst, bus.sclk); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_mid t=%0d ready got=%b want=1", t_rst, bus.ready); end
        total++; if (bus.rx_data !== '0) begin bad++; $display("FAIL reset_mid t=%0d rx_data got=%h want=0", t_rst, bus.rx_data); end
        repeat (3) begin
            @(negedge clk);
            if (bus.rx_valid !== 1'b0 || bus.cs_n !== 1'b1) ve++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.rx_valid !== 1'b0) ve++;
        end
        total++; if (ve !== 0) begin bad++; $display("FAIL reset_mid t=%0d stray rx_valid/cs_n cycles=%0d want 0", t_rst, ve); end
        tx = DW'($urandom);
        sw = DW'($urandom);
        test_slave("reset_mid_after", tx, sw);
    endtask

    task automatic test_random();
        logic [DW-1:0] tx;
        logic [DW-1:0] sw;
        for (int i = 0; i < 3; i++) begin
            tx = DW'($urandom);
            sw = DW'($urandom);
            test_slave("random", tx, sw);
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.tx_data = '0;
        test_reset();
        test_loopback();
        test_slave("slave", 16'hFFFF, 16'h3C5A);
        test_busy_drop();
        test_back_to_back();
        test_reset_mid(130);
        test_reset_mid(122);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_master.md
# spi_master

Single-frame SPI master that drives the team's SPI slave link (mode 0: CPOL=0, CPHA=0, MSB first). It turns a parallel word plus a start/ready handshake into one chip-select framed transfer on `cs_n`/`sclk`/`mosi`. It captures `miso` into a parallel receive word. All SPI timing is derived from `clk` by an integer divider, so the slave's oversampling synchronizers see clean, slow edges.

## Interface
- `DATA_WIDTH`, default 16: bits per frame; minimum 2.
- `CLK_DIV`, default 8: `clk` cycles per `sclk` half-period; minimum 8, which covers the slave's 4-cycle sync and edge-detect latency.
- `GAP_CYCLES`, default 8: minimum `clk` cycles `cs_n` stays high between frames; minimum 4.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request a transfer; accepted only when `start` and `ready` are both high.
- `tx_data`  in  DATA_WIDTH: word to send; sampled on the accept cycle only.
- `ready`  out  1: high when idle and able to accept `start`.
- `rx_data`  out  DATA_WIDTH: last received word; holds its value until the next frame completes.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` updates.
- `sclk`  out  1: SPI clock; idles low.
- `cs_n`  out  1: chip select, active-low.
- `mosi`  out  1: serial data out.
- `miso`  in  1: serial data in, asynchronous to `clk`.

## Operation
- All outputs are registered; there is no combinational path from any input to any output.
- Reset values: `ready`=1, `cs_n`=1, `sclk`=0, `mosi`=0, `rx_data`=0, `rx_valid`=0.
- `miso` passes through a 2-flop synchronizer (reset 0) before use.
- State machine: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - `ready`=1.
  - On `start` the block latches `tx_data` into the TX shift register and moves to SETUP.
  - On that same edge: `cs_n`←0, `mosi`←`tx_data[MSB]`, `ready`←0.
- SETUP: `sclk` stays low for CLK_DIV cycles, then moves to SHIFT.
- SHIFT: runs DATA_WIDTH bits. Each bit is a high half and a low half of CLK_DIV cycles each.
  - On the edge that drives `sclk` high, the synchronized `miso` is shifted into the RX register LSB (left shift).
  - On the edge that drives `sclk` low, `mosi` takes the next TX bit.
  - After the final bit's falling edge, `mosi`←0.
  - A bit counter (width `$clog2(DATA_WIDTH)+1`) counts rising edges and terminates SHIFT after the DATA_WIDTH-th falling edge.
- HOLD: `sclk` stays low for CLK_DIV cycles (the last low half). Then, on one edge: `cs_n`←1, `rx_data`←RX register, `rx_valid`←1.
- GAP: `cs_n` stays high and `ready` stays low for GAP_CYCLES cycles. `ready`←1 on the edge that enters IDLE.
- `start` while `ready`=0 is ignored, not queued. `tx_data` changes after accept have no effect.
- A `start` held high in IDLE launches back-to-back frames, still separated by GAP_CYCLES.
- Reset mid-frame aborts immediately to reset values: `cs_n` rises, no `rx_valid` pulse, partial RX data is discarded.
- Divider counter width is `$clog2(max(CLK_DIV,GAP_CYCLES))`. It reloads at each state or half-period boundary and never wraps mid-phase.

## Timing
- Take t=0 as the accept edge, where `cs_n` falls and `mosi`=MSB.
- Rising `sclk` edge for bit i (i=0 is the MSB) at t = CLK_DIV·(1+2i).
- Falling `sclk` edge for bit i at t = CLK_DIV·(2+2i).
- `cs_n` rises and `rx_valid` pulses at t = CLK_DIV·(1+2·DATA_WIDTH). With defaults this is t=264.
- `ready` returns at t = CLK_DIV·(1+2·DATA_WIDTH) + GAP_CYCLES. With defaults this is t=272.
- The earliest next `cs_n` fall is at 272, giving an accept-to-accept period of 272 cycles.
- Exactly DATA_WIDTH rising and DATA_WIDTH falling `sclk` edges per frame. `sclk` is never high while `cs_n`=1.
- `mosi` changes only at t=0 or on falling `sclk` edges.
- `miso` is sampled 2 `clk` cycles late relative to the pin. Because CLK_DIV ≥ 8, each slave MISO bit is stable ≥ 2 cycles before each rising edge.

## Test plan
- Reset: assert `rst_n`=0 with random inputs → `ready`=1, `cs_n`=1, `sclk`=0, `mosi`=0, `rx_valid`=0, `rx_data`=0.
- Loopback: `miso` tied to `mosi`, `tx_data`=16'hA5C3, `start` for 1 cycle → `cs_n` low for 264 cycles, 16 rising edges at t=8,24,…,248, `rx_valid` at t=264, `rx_data`=16'hA5C3, `ready` at t=272.
- Behavioural mode-0 slave returning 16'h3C5A while master sends 16'hFFFF → `rx_data`=16'h3C5A; slave receives 16'hFFFF.
- Busy drop: `start` with 16'h1234 pulsed again at t=100 with `tx_data`=16'hBEEF → single frame only; `mosi` serializes 16'h1234; no second `cs_n` fall.
- Back-to-back: `start` held high for 2 frames (16'h0001, then 16'h8000) → two `rx_valid` pulses 272 cycles apart; `cs_n` high for exactly 8 cycles between frames.
- Reset mid-frame: `rst_n` low at t=130 → `cs_n`=1 and `sclk`=0 immediately, no `rx_valid`. After release, a new frame completes normally.
